// File: rtl/s2p_nibble_rx.sv
// Serial-to-parallel receiver: MSB-first bits on sin/sin_vld assembled into WIDTH-bit words, buffered in a DEPTH-entry FIFO.
// Latency: a word is visible on dout/dout_vld right after the edge that samples its last bit.
// Backpressure: dout_rdy pops the FIFO; receiving never stalls, a word completing into a full FIFO is dropped with an ovf pulse.
module s2p_nibble_rx #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     sin,
  input  logic                     sin_vld,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_vld,
  input  logic                     dout_rdy,
  output logic                     busy,
  output logic                     frm_err,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GCNT_LAST = GW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t            state, state_nx;
  logic [WIDTH-2:0]  shreg, shreg_nx;
  logic [BW-1:0]     bcnt, bcnt_nx;
  logic [GW-1:0]     gcnt, gcnt_nx;
  logic              word_done, abort;
  logic [WIDTH-1:0]  word;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wp, rp;
  logic              pop, push_ok, drop;

  // Candidate word: held bits plus the bit on the wire this cycle.
  assign word = {shreg, sin};

  // Receive state register.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state <= IDLE;
      shreg <= '0;
      bcnt  <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      bcnt  <= bcnt_nx;
      gcnt  <= gcnt_nx;
    end
  end

  // Next-state: shift on strobe, count gaps inside a word, abort once the gap reaches TIMEOUT.
  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    bcnt_nx   = bcnt;
    gcnt_nx   = gcnt;
    word_done = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (sin_vld) begin
          state_nx = RECV;
          shreg_nx = word[WIDTH-2:0];
          bcnt_nx  = BW'(1);
          gcnt_nx  = '0;
        end
      end
      RECV: begin
        if (sin_vld) begin
          shreg_nx = word[WIDTH-2:0];
          gcnt_nx  = '0;
          if (bcnt == BCNT_LAST) begin
            word_done = 1'b1;
            bcnt_nx   = '0;
            state_nx  = IDLE;
          end else begin
            bcnt_nx = bcnt + BW'(1);
          end
        end else if (gcnt == GCNT_LAST) begin
          // Stale partial word: throw it away so nothing leaks into the next one.
          abort    = 1'b1;
          bcnt_nx  = '0;
          gcnt_nx  = '0;
          shreg_nx = '0;
          state_nx = IDLE;
        end else begin
          gcnt_nx = gcnt + GW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign pop     = dout_vld & dout_rdy;
  assign push_ok = word_done & ((level < LVL_FULL) | pop);
  assign drop    = word_done & ~push_ok;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push_ok) begin
        mem[wp] <= word;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      frm_err <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      frm_err <= abort;
      ovf     <= drop;
    end
  end

  assign dout     = mem[rp];
  assign dout_vld = (level != '0);
  assign busy     = (bcnt != '0);

endmodule

// File: doc/s2p_nibble_rx.md
# s2p_nibble_rx

Serial-to-parallel receiver for the nibble send path: it is the receive end of the parallel-to-serial sender. It samples one data bit per strobed cycle, MSB first, and assembles WIDTH-bit words. Completed words are buffered in a small FIFO and presented on a valid/ready output. Gaps inside a word are detected and aborted by timeout, and buffer overflow is reported.

## Interface
- WIDTH, 4, bits per word; must be ≥ 2
- DEPTH, 2, output FIFO entries; must be a power of 2 and ≥ 2
- TIMEOUT, 8, consecutive idle cycles inside a word that abort it; must be ≥ 1
- clk  input  1  clock; all state updates on the rising edge
- n_rst  input  1  asynchronous reset, active-high (1 = reset asserted)
- sin  input  1  serial data bit, sampled when sin_vld = 1
- sin_vld  input  1  bit strobe; one bit is taken per cycle it is high
- dout  output  WIDTH  word at the FIFO head; first received bit lands in dout[WIDTH-1]
- dout_vld  output  1  FIFO non-empty, so dout is valid
- dout_rdy  input  1  consumer accept; a pop occurs when dout_vld & dout_rdy
- busy  output  1  partial word in progress (bit count ≠ 0)
- frm_err  output  1  one-cycle pulse: partial word aborted by timeout
- ovf  output  1  one-cycle pulse: completed word dropped because the FIFO was full
- level  output  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Shift register shreg, bit counter bcnt (0..WIDTH-1), gap counter gcnt (0..TIMEOUT-1), FIFO mem/wp/rp/level.
- FSM has two states:
  - IDLE (bcnt = 0): on sin_vld go to RECV with shreg = {shreg, sin} and bcnt = 1. If WIDTH = 1 were allowed the word would complete here; WIDTH ≥ 2 is required.
  - RECV: on sin_vld shift the bit in, bcnt+1, and clear gcnt.
    - If this is bit WIDTH, the word {shreg[WIDTH-2:0], sin} completes, bcnt → 0 and the FSM returns to IDLE.
    - On !sin_vld, gcnt+1. If gcnt == TIMEOUT-1, abort: bcnt → 0, gcnt → 0, state → IDLE, frm_err = 1 for one cycle. Shift contents are discarded.
- Push happens on word completion.
  - The word is accepted if level < DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop).
  - Otherwise the word is dropped, ovf pulses for one cycle, and FIFO contents are unchanged.
- Pop happens when dout_vld & dout_rdy: rp advances and level decrements. dout_rdy while empty has no effect.
- Simultaneous push and pop: level is unchanged and both pointers advance. When level = 1, the head is popped and the new word becomes the head.
- wp and rp wrap modulo DEPTH.
- Receiving continues regardless of FIFO state. A bit arriving in the completion cycle of the previous word is not possible, because each bit is exactly one strobe.
- dout is mem[rp], driven combinationally from the registered FIFO. When dout_vld = 0, dout is don't-care but must not be X after reset.
- dout_vld = (level ≠ 0); busy = (bcnt ≠ 0).

## Timing
- Reset values (async, immediate on n_rst = 1):
  - state IDLE; bcnt, gcnt, shreg, wp, rp, level = 0; mem cleared.
  - dout = 0, dout_vld = 0, busy = 0, frm_err = 0, ovf = 0, level = 0.
- Reset mid-word or with a non-empty FIFO discards everything. There are no pulses on reset release.
- Latency: on the rising edge that samples bit WIDTH, dout_vld = 1 and dout = word take effect immediately after that edge. That is 0 cycles after the final bit's cycle, visible in the next cycle.
- The timeout fires at the edge ending the TIMEOUT-th consecutive idle cycle after the last bit; frm_err is high for the following cycle. A strobe in the TIMEOUT-th idle cycle is a valid continuation, with no abort.
- frm_err and ovf are registered one-cycle pulses and never both set by the same word.
- busy falls at the completion edge or at the abort edge.
- Back-to-back strobes are allowed every cycle, giving a sustained rate of 1 word per WIDTH cycles.

## Test plan
- Reset, then bits 1,0,0,1 on 4 consecutive sin_vld cycles with dout_rdy = 0 → dout = 4'b1001, dout_vld = 1, level = 1, busy = 0; dout_rdy = 1 for one cycle → level = 0.
- Bits 1,1,0,0 with sin_vld toggling every other cycle (gaps of 1 < TIMEOUT) → dout = 4'b1100, frm_err stays 0.
- Bits 0,1 then 8 idle cycles → frm_err pulses once, busy = 0. Then bits 0,1,1,0 → dout = 4'b0110; no residue from the aborted word.
- dout_rdy = 0 and three words sent: 4'hA, 4'h5, 4'hF → level = 2, ovf pulses on the third, and the FIFO holds A then 5. Drain → A, 5, then dout_vld = 0.
- FIFO full (A, 5) with a word 4'h3 completing in the same cycle as dout_rdy = 1 → no ovf, level stays 2, FIFO holds 5 then 3.
- n_rst asserted after 2 bits with level = 1 → all outputs return to their reset values immediately. The next full word after release is received correctly.
